// File: rtl/pc_source_pkg.sv
// Shared types and helpers for the PC source / update unit.
package pc_source_pkg;

  // Control FSM: normal fetch flow or inside an exception handler.
  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } pc_state_e;

  // Misalignment cause for the default two-bit cause code. Units with a
  // different cause width use the all-ones code of that width instead.
  localparam int unsigned CAUSE_WIDTH_DEFAULT = 2;
  localparam logic [CAUSE_WIDTH_DEFAULT-1:0] CAUSE_MISALIGN = 2'b11;

  // Exception vector: base plus one word per cause code. Computed at 64 bits
  // so callers of any width up to 64 can truncate the result.
  function automatic logic [63:0] exc_vector(input logic [63:0] base,
                                             input logic [63:0] cause);
    return base + (cause << 2);
  endfunction

endpackage

// File: rtl/pc_source_select.sv
// Combinational NUM_SOURCES:1 next-PC mux with an out-of-range select flag.
module pc_source_select #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SOURCES = 4,
  parameter int SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources,
  output logic [DATA_WIDTH-1:0]             target,
  output logic                              out_of_range
);

  localparam int L_SLOTS = 2 ** SEL_WIDTH;

  // Pad the candidate list to a power of two so any select value indexes a
  // defined entry; padding slots read as zero and are flagged out of range.
  logic [DATA_WIDTH-1:0] w_slot [L_SLOTS];

  for (genvar g = 0; g < L_SLOTS; g++) begin : g_slot
    if (g < NUM_SOURCES) begin : g_real
      assign w_slot[g] = sources[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign w_slot[g] = '0;
    end
  end

  assign target       = w_slot[sel];
  assign out_of_range = (int'(sel) >= NUM_SOURCES);

endmodule

// File: rtl/pc_source_unit.sv
// Program-counter source and update unit: next-PC select, PC/EPC registers,
// branch gating, misaligned-target trap, exception entry/return and
// double-fault detection.
module pc_source_unit
  import pc_source_pkg::*;
#(
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   NUM_SOURCES = 4,
  parameter int                   SEL_WIDTH   = $clog2(NUM_SOURCES),
  parameter int                   CAUSE_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] EXC_BASE   = 32'h0000_0100,
  parameter int unsigned          EPC_OFFSET  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SEL_WIDTH-1:0]              pc_sel,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources,
  input  logic                              pc_write,
  input  logic                              pc_write_cond,
  input  logic                              cond,
  input  logic                              exc_req,
  input  logic [CAUSE_WIDTH-1:0]            exc_cause,
  input  logic                              eret,
  output logic [DATA_WIDTH-1:0]             pc,
  output logic [DATA_WIDTH-1:0]             epc,
  output logic                              in_handler,
  output logic                              misalign,
  output logic                              bad_sel,
  output logic                              double_fault
);

  localparam logic [CAUSE_WIDTH-1:0] L_CAUSE_MIS = {CAUSE_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0]  L_EPC_OFF   = DATA_WIDTH'(EPC_OFFSET);

  pc_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, r_epc, w_pc_nxt, w_epc_nxt;
  logic                  r_misalign, r_bad_sel, r_double_fault;
  logic                  w_misalign_nxt, w_bad_sel_nxt, w_double_fault_nxt;

  logic [DATA_WIDTH-1:0] w_target, w_vec_exc, w_vec_mis, w_epc_capture;
  logic                  w_sel_oor, w_load, w_target_mis;

  pc_source_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SOURCES(NUM_SOURCES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_select (
    .sel         (pc_sel),
    .sources     (sources),
    .target      (w_target),
    .out_of_range(w_sel_oor)
  );

  assign w_load        = pc_write | (pc_write_cond & cond);
  assign w_target_mis  = (w_target[1:0] != 2'b00);
  assign w_vec_exc     = DATA_WIDTH'(exc_vector(64'(EXC_BASE), 64'(exc_cause)));
  assign w_vec_mis     = DATA_WIDTH'(exc_vector(64'(EXC_BASE), 64'(L_CAUSE_MIS)));
  // Wraps modulo 2^DATA_WIDTH, so pc = 0 captures the top of the space.
  assign w_epc_capture = r_pc - L_EPC_OFF;

  // State and datapath registers; reset may arrive in any cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_NORMAL;
      r_pc           <= RESET_PC;
      r_epc          <= '0;
      r_misalign     <= 1'b0;
      r_bad_sel      <= 1'b0;
      r_double_fault <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_epc          <= w_epc_nxt;
      r_misalign     <= w_misalign_nxt;
      r_bad_sel      <= w_bad_sel_nxt;
      r_double_fault <= w_double_fault_nxt;
    end
  end

  // Next FSM state: enter the handler on an exception or a trapped
  // misaligned load, leave it only on eret.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (exc_req) begin
          w_state_nxt = ST_HANDLER;
        end else if (eret) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_load && !w_sel_oor && w_target_mis) begin
          w_state_nxt = ST_HANDLER;
        end else begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_HANDLER: begin
        if (exc_req) begin
          w_state_nxt = ST_HANDLER;
        end else if (eret) begin
          w_state_nxt = ST_NORMAL;
        end else begin
          w_state_nxt = ST_HANDLER;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // Next PC/EPC and flag values; events are resolved strictly by priority,
  // so a lower-priority request in the same cycle is dropped.
  always_comb begin
    w_pc_nxt           = r_pc;
    w_epc_nxt          = r_epc;
    w_misalign_nxt     = 1'b0;
    w_bad_sel_nxt      = 1'b0;
    w_double_fault_nxt = r_double_fault;
    if (exc_req) begin
      if (r_state == ST_NORMAL) begin
        w_epc_nxt = w_epc_capture;
        w_pc_nxt  = w_vec_exc;
      end else begin
        w_double_fault_nxt = 1'b1;
      end
    end else if (eret) begin
      if (r_state == ST_HANDLER) begin
        w_pc_nxt = r_epc;
      end else begin
        w_pc_nxt = r_pc;
      end
    end else if (w_load) begin
      if (w_sel_oor) begin
        w_bad_sel_nxt = 1'b1;
      end else if (w_target_mis) begin
        w_misalign_nxt = 1'b1;
        if (r_state == ST_NORMAL) begin
          w_epc_nxt = w_epc_capture;
          w_pc_nxt  = w_vec_mis;
        end else begin
          w_double_fault_nxt = 1'b1;
        end
      end else begin
        w_pc_nxt = w_target;
      end
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  assign pc           = r_pc;
  assign epc          = r_epc;
  assign in_handler   = (r_state == ST_HANDLER);
  assign misalign     = r_misalign;
  assign bad_sel      = r_bad_sel;
  assign double_fault = r_double_fault;

endmodule

// File: doc/pc_source_unit.md
# pc_source_unit

Parametrised program-counter source and update unit for the multicycle datapath. Selects the next PC from `NUM_SOURCES` candidate buses, owns the PC and EPC registers, and handles conditional-branch gating, misaligned-target trapping, exception entry/return and double-fault detection. Replaces the fixed 4:1 combinational PC-source select. Feeds instruction memory and the register-bank write path.

## Interface
- `DATA_WIDTH`, 32, width of PC, EPC and every source bus
- `NUM_SOURCES`, 4, number of candidate next-PC buses, ≥2
- `SEL_WIDTH`, `$clog2(NUM_SOURCES)`, width of `pc_sel`
- `CAUSE_WIDTH`, 2, width of exception cause code
- `RESET_PC`, 0, PC value after reset
- `EXC_BASE`, 32'h0000_0100, exception vector base
- `EPC_OFFSET`, 4, subtracted from PC when EPC is captured
---
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `pc_sel`  in  SEL_WIDTH  source index
- `sources`  in  NUM_SOURCES*DATA_WIDTH  flattened candidates; source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `pc_write`  in  1  unconditional PC load
- `pc_write_cond`  in  1  PC load gated by `cond`
- `cond`  in  1  branch condition (e.g. ALU zero)
- `exc_req`  in  1  external exception request
- `exc_cause`  in  CAUSE_WIDTH  cause code for `exc_req`
- `eret`  in  1  return from handler
- `pc`  out  DATA_WIDTH  current PC (registered)
- `epc`  out  DATA_WIDTH  exception PC (registered)
- `in_handler`  out  1  FSM in HANDLER
- `misalign`  out  1  one-cycle pulse: misaligned target trapped
- `bad_sel`  out  1  one-cycle pulse: `pc_sel ≥ NUM_SOURCES` on a load
- `double_fault`  out  1  sticky until reset

## Operation
- `load = pc_write | (pc_write_cond & cond)`; `target = sources[pc_sel]`.
- Cause `{CAUSE_WIDTH{1'b1}}` is reserved for misalignment; vector(c) = `EXC_BASE + (c << 2)`.
- FSM states: NORMAL, HANDLER. Per-edge priority, highest first:
  1. `exc_req`: in NORMAL → `epc <= pc - EPC_OFFSET`, `pc <= vector(exc_cause)`, → HANDLER. In HANDLER → `double_fault <= 1`, pc/epc unchanged, stay.
  2. `eret`: in HANDLER → `pc <= epc`, → NORMAL. In NORMAL → ignored, no state change.
  3. `load` with `pc_sel ≥ NUM_SOURCES` → pc held, `bad_sel` pulse.
  4. `load` with `target[1:0] != 0`: in NORMAL → `misalign` pulse, `epc <= pc - EPC_OFFSET`, `pc <= vector(misalign cause)`, → HANDLER. In HANDLER → `misalign` pulse, `double_fault <= 1`, pc held.
  5. `load` otherwise → `pc <= target`.
  6. none → hold.
- A lower-priority event coinciding with a higher one is dropped, not queued.
- `double_fault` blocks nothing; the FSM keeps working, only the flag sticks.
- Subtraction wraps modulo 2^DATA_WIDTH (`pc = 0` → `epc = 2^DATA_WIDTH - EPC_OFFSET`).

## Timing
- All outputs registered; every update takes effect at the edge after the inputs are sampled (1-cycle latency). No combinational input→output path.
- `misalign`, `bad_sel`: high exactly one cycle after the offending edge, unless re-triggered.
- Reset (asynchronous, any cycle, including mid-handler): `pc = RESET_PC`, `epc = 0`, state NORMAL, `in_handler = 0`, `misalign = 0`, `bad_sel = 0`, `double_fault = 0`.
- First load accepted on the first rising edge after `reset` deasserts.

## Structure
- Package `pc_source_pkg`: FSM state enum (NORMAL, HANDLER), `CAUSE_MISALIGN` constant, vector-computation function.
- Sub-module `pc_source_select`: purely combinational parametrised NUM_SOURCES:1 mux with out-of-range flag; everything sequential stays in `pc_source_unit`.

## Test plan
- Reset, then `pc_write=1`, `pc_sel=1`, source1=32'h40 → `pc=32'h40` next cycle. Then `pc_write_cond=1`, `cond=0` → pc stays 32'h40. Then `cond=1`, source2=32'h80 → `pc=32'h80`.
- `pc=32'h80`, `exc_req=1`, `exc_cause=1` → `epc=32'h7C`, `pc=32'h104`, `in_handler=1`. Then `eret` → `pc=32'h7C`, `in_handler=0`.
- Load with target 32'h42 in NORMAL → `misalign` pulse, `pc=32'h10C`, `in_handler=1`. Then `exc_req` in HANDLER → `double_fault=1`, pc held at 32'h10C.
- `NUM_SOURCES=3`, `pc_sel=3`, `pc_write=1` → `bad_sel` one-cycle pulse, pc unchanged.
- Same edge: `exc_req` + `eret` + `pc_write` in NORMAL → exception wins, `pc=vector(exc_cause)`, load dropped. At `pc=0`, `exc_req` → `epc=32'hFFFF_FFFC`.
- Assert `reset` mid-handler with `double_fault=1` → all outputs return to reset values asynchronously, before the next clock edge.
